// File: rtl/display_scan_ctrl.sv
// 4-digit active-low 7-segment scan controller with a round-robin byte-write
// arbiter feeding a 16-bit display buffer and blanking gaps between digits.
module display_scan_ctrl #(
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLANK_CYCLES = 1000
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       a_valid_i,
  input  logic       a_addr_i,
  input  logic [7:0] a_data_i,
  output logic       a_ready_o,
  input  logic       b_valid_i,
  input  logic       b_addr_i,
  input  logic [7:0] b_data_i,
  output logic       b_ready_o,
  input  logic [3:0] en_mask_i,
  output logic [3:0] an_o,
  output logic [6:0] seg_o,
  output logic [3:0] digit_o,
  output logic       frame_o
);

  localparam int unsigned CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] DRIVE_LAST = CW'(REFRESH_DIV - 1);

  typedef enum logic {ST_BLANK, ST_DRIVE} state_e;
  typedef enum logic {PORT_A, PORT_B} port_e;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [3:0]    digit_q, digit_d;
  logic [15:0]   buf_q;
  port_e         rr_q;
  logic [3:0]    an_q;
  logic [6:0]    seg_q;
  logic          frame_q;
  logic          a_grant, b_grant;

  always_comb begin
    a_grant = a_valid_i && (!b_valid_i || rr_q == PORT_A);
    b_grant = b_valid_i && (!a_valid_i || rr_q == PORT_B);
  end

  assign a_ready_o = a_grant;
  assign b_ready_o = b_grant;

  // The digit is latched from the buffer before this edge's write lands.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    idx_d   = idx_q;
    digit_d = digit_q;
    case (state_q)
      ST_BLANK: if (cnt_q == BLANK_LAST) begin
        state_d = ST_DRIVE;
        cnt_d   = '0;
        digit_d = buf_q[{idx_q, 2'b00} +: 4];
      end
      default: if (cnt_q == DRIVE_LAST) begin
        state_d = ST_BLANK;
        cnt_d   = '0;
        idx_d   = idx_q + 2'd1;
      end
    endcase
  end

  // an/seg/frame are computed from next state so they line up with it.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= ST_BLANK;
      cnt_q   <= '0;
      idx_q   <= '0;
      digit_q <= '0;
      buf_q   <= '0;
      rr_q    <= PORT_A;
      an_q    <= '1;
      seg_q   <= '1;
      frame_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      digit_q <= digit_d;
      an_q    <= (state_d == ST_DRIVE) ? ~(4'b0001 << idx_d) : '1;
      seg_q   <= (state_d == ST_DRIVE) ? hex7(digit_d) : '1;
      frame_q <= (state_d == ST_DRIVE) && (idx_d == 2'd3) && (cnt_d == DRIVE_LAST);
      if (a_grant) begin
        buf_q[{a_addr_i, 3'b000} +: 8] <= a_data_i;
        rr_q <= PORT_B;
      end else if (b_grant) begin
        buf_q[{b_addr_i, 3'b000} +: 8] <= b_data_i;
        rr_q <= PORT_A;
      end
    end
  end

  // Mask gates the registered drive so it applies mid-slot.
  assign an_o    = en_mask_i[idx_q] ? an_q  : '1;
  assign seg_o   = en_mask_i[idx_q] ? seg_q : '1;
  assign digit_o = digit_q;
  assign frame_o = frame_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Randomized bench for display_scan_ctrl checked against a time-indexed
// reference model of the scan, buffer and round-robin arbiter.
module tb_display_scan_ctrl;

  localparam int unsigned RD    = 4;
  localparam int unsigned BC    = 2;
  localparam int unsigned SLOT  = RD + BC;
  localparam int unsigned FRAME = 4 * SLOT;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       a_valid, a_addr, a_ready;
  logic [7:0] a_data;
  logic       b_valid, b_addr, b_ready;
  logic [7:0] b_data;
  logic [3:0] en_mask;
  logic [3:0] an, digit;
  logic [6:0] seg;
  logic       frame;

  display_scan_ctrl #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .a_valid_i(a_valid), .a_addr_i(a_addr), .a_data_i(a_data), .a_ready_o(a_ready),
    .b_valid_i(b_valid), .b_addr_i(b_addr), .b_data_i(b_data), .b_ready_o(b_ready),
    .en_mask_i(en_mask), .an_o(an), .seg_o(seg), .digit_o(digit), .frame_o(frame)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int frames_seen = 0;

  // Reference model: t_m = cycles since reset release, buffer bytes, rr, shown digit.
  int         t_m;
  logic [7:0] buf_m [2];
  bit         rr_m;
  logic [3:0] dig_m;
  logic [6:0] hex_t [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                             7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                             7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                             7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0d)", tag, got, exp, t_m);
    end
  endtask

  function automatic logic [3:0] nib(input int d);
    logic [7:0] b;
    b = buf_m[d / 2];
    return (d % 2 == 1) ? b[7:4] : b[3:0];
  endfunction

  task automatic model_reset();
    t_m = 0;
    buf_m[0] = '0;
    buf_m[1] = '0;
    rr_m = 0;
    dig_m = '0;
  endtask

  // Inputs for this cycle are already driven; check, then advance one edge.
  task automatic cycle();
    int pos, d;
    bit ga, gb;
    logic [1:0] d2;
    logic [3:0] ean;
    logic [6:0] eseg;
    #1;
    pos = t_m % SLOT;
    d   = (t_m / SLOT) % 4;
    d2  = d[1:0];
    ga  = a_valid && (!b_valid || !rr_m);
    gb  = b_valid && (!a_valid || rr_m);
    if (pos < BC || !en_mask[d2]) begin
      ean  = 4'hF;
      eseg = 7'h7F;
    end else begin
      ean  = ~(4'b0001 << d2);
      eseg = hex_t[dig_m];
    end
    check_eq("an", 32'(an), 32'(ean));
    check_eq("seg", 32'(seg), 32'(eseg));
    check_eq("digit", 32'(digit), 32'(dig_m));
    check_eq("frame", 32'(frame), 32'(t_m % FRAME == FRAME - 1));
    check_eq("a_ready", 32'(a_ready), 32'(ga));
    check_eq("b_ready", 32'(b_ready), 32'(gb));
    if (frame === 1'b1) frames_seen++;
    @(posedge clk);
    if (!rst_n) model_reset();
    else begin
      t_m++;
      if (t_m % SLOT == BC) dig_m = nib((t_m / SLOT) % 4);
      if (ga) begin buf_m[a_addr] = a_data; rr_m = 1; end
      else if (gb) begin buf_m[b_addr] = b_data; rr_m = 0; end
    end
    #1;
  endtask

  task automatic idle(input int n);
    a_valid = 0;
    b_valid = 0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic wait_phase(input int ph);
    a_valid = 0;
    b_valid = 0;
    for (int i = 0; i < 2 * FRAME && (t_m % FRAME) != ph; i++) cycle();
    check_eq("phase_reached", 32'(t_m % FRAME), 32'(ph));
  endtask

  task automatic wr_a(input logic ad, input logic [7:0] dt);
    a_valid = 1; a_addr = ad; a_data = dt; b_valid = 0;
    cycle();
    a_valid = 0;
  endtask

  initial begin
    rst_n = 0; en_mask = 4'hF;
    a_valid = 0; a_addr = 0; a_data = '0;
    b_valid = 0; b_addr = 0; b_data = '0;
    @(posedge clk);
    #1;
    model_reset();
    rst_n = 1;

    // Idle frame: exactly one frame pulse.
    frames_seen = 0;
    idle(FRAME);
    check_eq("frame_count", 32'(frames_seen), 32'd1);

    wr_a(1'b0, 8'hA5);
    wr_a(1'b1, 8'h3C);
    idle(2 * FRAME);

    // Both ports contend on byte 0.
    a_valid = 1; a_addr = 0; a_data = 8'h11;
    b_valid = 1; b_addr = 0; b_data = 8'h22;
    for (int i = 0; i < 4; i++) cycle();
    idle(FRAME);

    // Write during digit0's DRIVE slot: tear-free display.
    wait_phase(3);
    wr_a(1'b0, 8'hFF);
    idle(FRAME + 4);

    wait_phase(0);
    en_mask = 4'b1010;
    idle(FRAME);
    en_mask = 4'hF;

    // One-cycle reset in the middle of digit2's DRIVE.
    wait_phase(14);
    rst_n = 0;
    cycle();
    rst_n = 1;
    idle(FRAME);

    for (int i = 0; i < 3000; i++) begin
      a_valid = 1'($urandom);
      a_addr  = 1'($urandom);
      a_data  = 8'($urandom);
      b_valid = 1'($urandom);
      b_addr  = 1'($urandom);
      b_data  = 8'($urandom);
      if ($urandom_range(0, 15) == 0) en_mask = 4'($urandom);
      rst_n = ($urandom_range(0, 499) != 0);
      cycle();
    end
    rst_n = 1;
    idle(FRAME);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
